// File: rtl/flash_pkg.sv
// Shared constants for the flash emulator: command opcodes, status/control bit
// positions and the controller state encoding.
`timescale 1ns/1ps
package flash_pkg;

  localparam int DATA_W = 16;

  localparam logic [7:0] OP_READ_ARRAY   = 8'hFF;
  localparam logic [7:0] OP_READ_STATUS  = 8'h70;
  localparam logic [7:0] OP_CLEAR_STATUS = 8'h50;
  localparam logic [7:0] OP_PROGRAM      = 8'h40;
  localparam logic [7:0] OP_ERASE        = 8'h20;
  localparam logic [7:0] OP_CONFIRM      = 8'hD0;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPEN_LOW  = 3;
  localparam logic [7:0] SR_RESET = 8'h80;

  // flash_ctl = {byte, ce, ce1, ce2, oe, rp, vpen, we}
  localparam int CTL_BYTE = 7;
  localparam int CTL_CE   = 6;
  localparam int CTL_CE1  = 5;
  localparam int CTL_CE2  = 4;
  localparam int CTL_OE   = 3;
  localparam int CTL_RP   = 2;
  localparam int CTL_VPEN = 1;
  localparam int CTL_WE   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PROG_SETUP,
    ST_PROG_RD,
    ST_PROG_BUSY,
    ST_ERASE_SETUP,
    ST_ERASE_SWEEP,
    ST_ERASE_WAIT
  } flash_state_t;

  typedef enum logic {
    MODE_ARRAY,
    MODE_STATUS
  } flash_mode_t;

endpackage

// File: rtl/flash_emu_ram.sv
// Single-port synchronous RAM backing the emulated flash array, registered read.
`timescale 1ns/1ps
module flash_emu_ram
  import flash_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  // Words are stored inverted so zeroed power-up RAM reads back as erased 0xFFFF.
  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= ~wdata;
    end
    rdata <= ~mem[addr];
  end

endmodule

// File: rtl/flash_emulator.sv
// Device side of a 16-bit Intel-style command-set flash bus backed by on-chip RAM:
// decodes read/status/clear/program/erase strobes and drives array or status data.
`timescale 1ns/1ps
module flash_emulator
  import flash_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int BLOCK_W     = 6,
  parameter int PROG_CYCLES = 8,
  parameter int ERASE_EXTRA = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [22:0]  flash_addr,
  inout  wire  [15:0]  flash_data,
  input  logic [7:0]   flash_ctl,
  output flash_state_t dbg_state
);

  localparam int CNT_MAX = (PROG_CYCLES > ERASE_EXTRA) ? PROG_CYCLES : ERASE_EXTRA;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  logic ce_n, oe_n, rp, vpen, we;
  assign ce_n = flash_ctl[CTL_CE];
  assign oe_n = flash_ctl[CTL_OE];
  assign rp   = flash_ctl[CTL_RP];
  assign vpen = flash_ctl[CTL_VPEN];
  assign we   = flash_ctl[CTL_WE];

  logic unused_ok;
  assign unused_ok = ^{flash_addr[0], flash_addr[22:ADDR_W+1],
                       flash_ctl[CTL_BYTE], flash_ctl[CTL_CE1], flash_ctl[CTL_CE2]};

  flash_state_t              state;
  flash_mode_t               mode;
  logic [7:0]                sr;
  logic                      we_q;
  logic [CNT_W-1:0]          cnt;
  logic [BLOCK_W-1:0]        sweep;
  logic [ADDR_W-1:0]         prog_addr;
  logic [DATA_W-1:0]         prog_data;
  logic [ADDR_W-BLOCK_W-1:0] blk_addr;

  logic                      hold_rst, strobe;
  logic [DATA_W-1:0]         din;
  logic [7:0]                opc;
  logic [ADDR_W-1:0]         cur_addr;

  // A command is the rising edge of we (registered we_q low, live we high)
  // while ce is asserted; data and address are taken on that same clock.
  assign hold_rst = rst | ~rp;
  assign strobe   = ~we_q & we & ~ce_n;
  assign din      = flash_data;
  assign opc      = din[7:0];
  assign cur_addr = flash_addr[ADDR_W:1];

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_q;

  always_comb begin
    ram_addr  = cur_addr;
    ram_we    = 1'b0;
    ram_wdata = '1;
    case (state)
      ST_PROG_RD: ram_addr = prog_addr;
      ST_PROG_BUSY: begin
        // ram_q still holds the old word; programming can only clear bits.
        ram_addr  = prog_addr;
        ram_we    = (cnt == CNT_W'(PROG_CYCLES)) & ~hold_rst;
        ram_wdata = ram_q & prog_data;
      end
      ST_ERASE_SWEEP: begin
        ram_addr = {blk_addr, sweep};
        ram_we   = ~hold_rst;
      end
      default: ;
    endcase
  end

  flash_emu_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (hold_rst) begin
      state <= ST_IDLE;
      mode  <= MODE_ARRAY;
      sr    <= SR_RESET;
      we_q  <= 1'b1;
      cnt   <= '0;
      sweep <= '0;
    end else begin
      we_q <= we;
      case (state)
        ST_IDLE: begin
          if (strobe) begin
            case (opc)
              OP_READ_ARRAY:  mode <= MODE_ARRAY;
              OP_READ_STATUS: mode <= MODE_STATUS;
              OP_CLEAR_STATUS: begin
                sr[SR_ERASE_ERR] <= 1'b0;
                sr[SR_PROG_ERR]  <= 1'b0;
                sr[SR_VPEN_LOW]  <= 1'b0;
              end
              OP_PROGRAM: begin
                mode  <= MODE_STATUS;
                state <= ST_PROG_SETUP;
              end
              OP_ERASE: begin
                mode  <= MODE_STATUS;
                state <= ST_ERASE_SETUP;
              end
              default: ;
            endcase
          end
        end
        ST_PROG_SETUP: begin
          if (strobe) begin
            if (!vpen) begin
              sr[SR_VPEN_LOW] <= 1'b1;
              sr[SR_PROG_ERR] <= 1'b1;
              state           <= ST_IDLE;
            end else begin
              prog_addr    <= cur_addr;
              prog_data    <= din;
              sr[SR_READY] <= 1'b0;
              state        <= ST_PROG_RD;
            end
          end
        end
        ST_PROG_RD: begin
          cnt   <= '0;
          state <= ST_PROG_BUSY;
        end
        ST_PROG_BUSY: begin
          if (cnt == CNT_W'(PROG_CYCLES)) begin
            sr[SR_READY] <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_ERASE_SETUP: begin
          if (strobe) begin
            if (opc != OP_CONFIRM) begin
              sr[SR_ERASE_ERR] <= 1'b1;
              sr[SR_PROG_ERR]  <= 1'b1;
              state            <= ST_IDLE;
            end else if (!vpen) begin
              sr[SR_VPEN_LOW]  <= 1'b1;
              sr[SR_ERASE_ERR] <= 1'b1;
              state            <= ST_IDLE;
            end else begin
              blk_addr     <= cur_addr[ADDR_W-1:BLOCK_W];
              sweep        <= '0;
              sr[SR_READY] <= 1'b0;
              state        <= ST_ERASE_SWEEP;
            end
          end
        end
        ST_ERASE_SWEEP: begin
          sweep <= sweep + BLOCK_W'(1);
          if (&sweep) begin
            cnt   <= '0;
            state <= ST_ERASE_WAIT;
          end
        end
        ST_ERASE_WAIT: begin
          if (cnt == CNT_W'(ERASE_EXTRA)) begin
            sr[SR_READY] <= 1'b1;
            state        <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic              drive;
  logic [DATA_W-1:0] dout;
  assign drive      = ~ce_n & ~oe_n & rp;
  assign dout       = (mode == MODE_STATUS || !sr[SR_READY]) ? {8'h00, sr} : ram_q;
  assign flash_data = drive ? dout : 'z;
  assign dbg_state  = state;

endmodule
